bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It is parametrised in binary width and output digit count, and uses valid/ready handshakes on input and output. It is the successor to the fixed 10-line decimal-to-BCD encoders. It sits between binary datapath results (counters, ALU outputs) and decimal display or serial-print logic.

Parameters:
BIN_W, 8, width of the unsigned binary input (1..32).
DIGITS, 3, number of 4-bit BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; a violation is an elaboration-time error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  bin_in holds a value to convert
in_ready  output  1  block can accept a new value
bin_in  input  BIN_W  unsigned binary operand
out_valid  output  1  bcd_out holds a finished result
out_ready  input  1  consumer accepts the result
bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0]
busy  output  1  conversion in progress (state SHIFT)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, bcd_out=0, internal shift and count registers=0.
- Reset asserted mid-conversion or mid-output aborts immediately. No result is produced. After release, in_ready=1 on the first clock.

FSM states are IDLE, SHIFT and OUT.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid and in_ready are both high: capture bin_in into the binary shift register, clear the BCD register, set cnt=0, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge, in this order:
    - For every digit, if digit >= 5 add 3 (4-bit result; no carry out is possible).
    - Shift {bcd_reg, bin_reg} left by 1.
    - cnt++.
  - Exit when cnt reaches BIN_W-1, i.e. after exactly BIN_W shift edges. Then go to OUT.
- OUT:
  - out_valid=1; bcd_out is driven from a register and stays stable.
  - On the edge where out_valid and out_ready are both high: go to IDLE, out_valid=0.
- Latency: if acceptance occurs at edge E0, out_valid rises after edge E0+BIN_W. Minimum throughput is one result per BIN_W+2 cycles.
- Backpressure:
  - If out_ready is low, the block stays in OUT indefinitely with bcd_out held.
  - in_valid is ignored outside IDLE, and bin_in is not sampled outside IDLE.
- No simultaneous accept and deliver: in_ready is low in OUT even when out_ready=1.
- Boundaries:
  - bin_in=0 gives all-zero digits.
  - bin_in=2^BIN_W-1 gives the maximum value with no overflow, guaranteed by the parameter rule.
  - BIN_W=1 gives one shift cycle.
- cnt width is clog2(BIN_W), minimum 1 bit. It never wraps within a conversion.
- Unused high digits, where DIGITS exceeds what is required, read 0.

Decomposition:
- Shared package/header bcd_defs:
  - BCD_DIGIT_W=4
  - ADJ_THRESH=5
  - ADJ_ADD=3
  - state encodings ST_IDLE, ST_SHIFT, ST_OUT
- Sub-module bcd_digit_adj: combinational 4-bit digit in, add-3-if->=5 digit out. It is instantiated DIGITS times via generate.
- The top level holds the FSM, counter and shift registers.

Test Plan:
1. BIN_W=8, DIGITS=3, out_ready=1; send 255 -> bcd_out=12'h255, out_valid rises exactly 8 cycles after the accept edge, busy high for those 8 cycles.
2. Send 0, then 99, then 100 back-to-back with in_valid held high -> 12'h000, 12'h099, 12'h100 in order; in_ready is low between accepts; each conversion takes 10 cycles.
3. Backpressure: send 37, hold out_ready=0 for 6 cycles while driving in_valid=1 with bin_in=200 -> bcd_out stays 12'h037 and in_ready stays 0. Raise out_ready -> the next accepted result is 12'h200.
4. Reset: assert rst_n=0 asynchronously mid-cycle, 4 shift edges into converting 173 -> out_valid, busy and bcd_out go to 0 immediately; in_ready=1 after release; 173 is never output.
5. BIN_W=16, DIGITS=5: send 65535 -> 20'h65535 after 16 cycles. Send 1 -> 20'h00001.
6. Exhaustive, BIN_W=8: all 256 inputs compared against a behavioural reference model (/10 and %10 digit extraction) -> zero mismatches.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants, state encoding and parameter legality check for the
// sequential double-dabble binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned ADJ_THRESH  = 5;
  localparam int unsigned ADJ_ADD     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit digits_fit(input int unsigned bin_w, input int unsigned digits);
    longint unsigned pow10;
    pow10 = 64'd1;
    for (int unsigned i = 0; i < digits && i < 19; i++) pow10 = pow10 * 64'd10;
    return pow10 > ((64'd1 << bin_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready handshake bundle between a binary producer and the BCD converter.
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);
  import bin2bcd_seq_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [BIN_W-1:0]              bin_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
  logic                          busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, busy
  );
endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// One BCD digit correction step: add 3 when the digit is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bin2bcd_seq_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit_c
);

  always_comb begin
    o_digit_c = i_digit;
    if (i_digit >= BCD_DIGIT_W'(ADJ_THRESH)) o_digit_c = i_digit + BCD_DIGIT_W'(ADJ_ADD);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: accepts one operand, runs BIN_W
// shift-and-add-3 steps, then holds the packed BCD result until taken.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic          clk,
  input logic          rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CAT_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
    $error("bin2bcd_seq: BIN_W must be in 1..32");
  end
  if (!digits_fit(BIN_W, DIGITS)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;

  logic [BCD_W-1:0]   w_adj;
  logic [CAT_W-1:0]   w_cat;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_seq_digit_adj u_adj (
      .i_digit   (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit_c (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjusted digits and remaining binary bits move left together.
  assign w_cat = {w_adj, r_bin} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_bin      <= bus.bin_in;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bin <= w_cat[BIN_W-1:0];
          r_bcd <= w_cat[CAT_W-1:BIN_W];
          // Counter stops at BIN_W-1 instead of wrapping on the last step.
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.bcd_out   = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 8-bit and 16-bit instances checked against a
// divide/modulo decimal reference, including handshake timing and reset abort.
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;

  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if8  ();
  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if16 ();

  bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal digits by repeated division, packed ones-digit first.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic wait_ready8();
    int w;
    w = 0;
    while (!if8.in_ready && w < 50) begin tick(); w++; end
    if (!if8.in_ready) chk("ready8_timeout", 64'(if8.in_ready), 64'd1);
  endtask

  task automatic wait_ready16();
    int w;
    w = 0;
    while (!if16.in_ready && w < 50) begin tick(); w++; end
    if (!if16.in_ready) chk("ready16_timeout", 64'(if16.in_ready), 64'd1);
  endtask

  task automatic conv8(input int unsigned v, input int unsigned stall);
    int unsigned lat, nbusy, bad;
    logic [11:0] held;
    wait_ready8();
    if8.bin_in    = 8'(v);
    if8.in_valid  = 1'b1;
    if8.out_ready = (stall == 0);
    tick();
    if8.in_valid = 1'b0;
    lat = 0; nbusy = 0;
    while (!if8.out_valid && lat < 100) begin
      if (if8.busy) nbusy++;
      tick();
      lat++;
    end
    chk("lat8", 64'(lat), 64'd8);
    chk("busy8", 64'(nbusy), 64'd8);
    chk("bcd8", 64'(if8.bcd_out), ref_bcd(64'(v), 3));
    held = if8.bcd_out;
    bad = 0;
    for (int i = 0; i < int'(stall); i++) begin
      tick();
      if (!if8.out_valid || if8.bcd_out !== held || if8.in_ready) bad++;
    end
    if (stall != 0) chk("hold8", 64'(bad), 64'd0);
    if8.out_ready = 1'b1;
    tick();
    chk("deliver8", 64'(if8.out_valid), 64'd0);
  endtask

  task automatic conv16(input int unsigned v, input int unsigned stall);
    int unsigned lat;
    wait_ready16();
    if16.bin_in    = 16'(v);
    if16.in_valid  = 1'b1;
    if16.out_ready = (stall == 0);
    tick();
    if16.in_valid = 1'b0;
    lat = 0;
    while (!if16.out_valid && lat < 100) begin tick(); lat++; end
    chk("lat16", 64'(lat), 64'd16);
    chk("bcd16", 64'(if16.bcd_out), ref_bcd(64'(v), 5));
    repeat (stall) tick();
    if16.out_ready = 1'b1;
    tick();
    chk("deliver16", 64'(if16.out_valid), 64'd0);
  endtask

  initial begin
    int unsigned perm [256];
    int acc [3];
    int unsigned vals [3];
    logic [11:0] exp2 [3];
    int unsigned bad, lat;

    n_vec = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0;
    if8.in_valid = 1'b0;  if8.bin_in = '0;  if8.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.bin_in = '0; if16.out_ready = 1'b1;
    #23;
    chk("rst_in_ready",  64'(if8.in_ready),  64'd1);
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_busy",      64'(if8.busy),      64'd0);
    chk("rst_bcd",       64'(if8.bcd_out),   64'd0);
    chk("rst_bcd16",     64'(if16.bcd_out),  64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Largest 8-bit operand with exact latency and busy window.
    conv8(255, 0);
    wait_ready8();
    if8.bin_in = 8'd255; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 100) begin tick(); lat++; end
    chk("t1_bcd_255", 64'(if8.bcd_out), 64'h255);
    tick();

    // Back-to-back operands with in_valid held high.
    vals[0] = 0; vals[1] = 99; vals[2] = 100;
    exp2[0] = 12'h000; exp2[1] = 12'h099; exp2[2] = 12'h100;
    if8.out_ready = 1'b1;
    if8.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if8.bin_in = 8'(vals[k]);
      wait_ready8();
      tick();
      acc[k] = cyc;
      bad = 0; lat = 0;
      while (!if8.out_valid && lat < 100) begin
        if (if8.in_ready) bad++;
        tick();
        lat++;
      end
      chk("t2_bcd", 64'(if8.bcd_out), 64'(exp2[k]));
      chk("t2_ready_low", 64'(bad + 32'(if8.in_ready)), 64'd0);
    end
    if8.in_valid = 1'b0;
    chk("t2_period01", 64'(acc[1] - acc[0]), 64'd10);
    chk("t2_period12", 64'(acc[2] - acc[1]), 64'd10);
    tick();

    // Backpressure: result held while a new operand waits.
    wait_ready8();
    if8.out_ready = 1'b0;
    if8.bin_in = 8'd37; if8.in_valid = 1'b1;
    tick();
    if8.bin_in = 8'd200;
    lat = 0;
    while (!if8.out_valid && lat < 100) begin tick(); lat++; end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if8.bcd_out !== 12'h037 || if8.in_ready || !if8.out_valid) bad++;
    end
    chk("t3_bcd_37", 64'(if8.bcd_out), 64'h037);
    chk("t3_held", 64'(bad), 64'd0);
    if8.out_ready = 1'b1;
    tick();
    wait_ready8();
    tick();
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 100) begin tick(); lat++; end
    chk("t3_bcd_200", 64'(if8.bcd_out), 64'h200);
    tick();

    // Asynchronous reset four shift edges into a conversion.
    wait_ready8();
    if8.bin_in = 8'd173; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t4_out_valid", 64'(if8.out_valid), 64'd0);
    chk("t4_busy",      64'(if8.busy),      64'd0);
    chk("t4_bcd",       64'(if8.bcd_out),   64'd0);
    chk("t4_in_ready",  64'(if8.in_ready),  64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t4_ready_after", 64'(if8.in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (if8.out_valid || if8.busy) bad++;
      tick();
    end
    chk("t4_no_result", 64'(bad), 64'd0);

    // 16-bit instance boundaries.
    conv16(65535, 0);
    chk("t5_bcd_65535", 64'(ref_bcd(64'd65535, 5)), 64'h65535);
    conv16(1, 1);
    conv16(0, 0);
    for (int i = 0; i < 30; i++) conv16($urandom_range(0, 65535), $urandom_range(0, 3));

    // Every 8-bit operand, in shuffled order with random stalls.
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int unsigned j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 256; i++) conv8(perm[i], $urandom_range(0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
